mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/isa_types.sv | 29 ++
 rtl/mem_arb_grant.sv | 34 +++
 rtl/mem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/isa_types.sv
// Shared ISA-level types: write widths, memory arbiter state, requester
// identities and the default memory read latency.
package isa_types;

  localparam int XLEN                 = 32;
  localparam int READ_LATENCY_DEFAULT = 2;

  typedef enum logic [1:0] {
    WIDTH_BYTE = 2'd0,
    WIDTH_HALF = 2'd1,
    WIDTH_WORD = 2'd2
  } write_width_t;

  typedef enum logic {
    IDLE      = 1'b0,
    READ_WAIT = 1'b1
  } arb_state_t;

  typedef enum logic {
    PORT_HART = 1'b0,
    PORT_AUX  = 1'b1
  } mem_port_t;

  // Map a one-hot two-port grant vector onto the requester identity.
  function automatic mem_port_t onehot_to_port(input logic [1:0] grant);
    return grant[1] ? PORT_AUX : PORT_HART;
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Two-requester grant selection for mem_arbiter.
// Optional feature macro: MEM_ARBITER_ROUND_ROBIN_EN (alternate on ties);
// when undefined, port 0 wins every tie and last_grant_i is ignored.
module mem_arb_grant
  import isa_types::*;
(
  input  logic [1:0] valid_i,
  input  mem_port_t  last_grant_i,
  input  logic       idle_i,
  output logic [1:0] grant_o
);

`ifndef MEM_ARBITER_ROUND_ROBIN_EN
  logic unused_last_grant_s;
  assign unused_last_grant_s = last_grant_i;
`endif

  // Choose at most one valid requester while the arbiter is free.
  always_comb begin
    grant_o = 2'b00;
    if (!idle_i) begin
      grant_o = 2'b00;
    end else if (valid_i == 2'b11) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      grant_o = (last_grant_i == PORT_HART) ? 2'b10 : 2'b01;
`else
      grant_o = 2'b01;
`endif
    end else begin
      grant_o = valid_i;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter. Writes complete in the acceptance cycle with a
// response pulse one cycle later; reads block the arbiter for READ_LATENCY
// cycles plus one capture cycle, then pulse the response with the data.
// Optional feature macro: MEM_ARBITER_ROUND_ROBIN_EN (round-robin tie-break).
module mem_arbiter
  import isa_types::*;
#(
  parameter int READ_LATENCY = READ_LATENCY_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [XLEN-1:0]  req0_addr,
  input  logic             req0_wenable,
  input  write_width_t     req0_wwidth,
  input  logic [XLEN-1:0]  req0_wdata,
  output logic             resp0_valid,
  output logic [XLEN-1:0]  resp0_rdata,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [XLEN-1:0]  req1_addr,
  input  logic             req1_wenable,
  input  write_width_t     req1_wwidth,
  input  logic [XLEN-1:0]  req1_wdata,
  output logic             resp1_valid,
  output logic [XLEN-1:0]  resp1_rdata,

  output logic [XLEN-1:0]  mem_addr,
  output write_width_t     mem_wwidth,
  output logic             mem_wenable,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic [XLEN-1:0]  mem_rdata
);

  localparam int CNT_W = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mem_port_t         port_q, port_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [1:0]        resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]   rdata0_q, rdata0_d;
  logic [XLEN-1:0]   rdata1_q, rdata1_d;
  mem_port_t         last_grant_s;

  logic [1:0]        grant_s;
  logic              idle_s;
  logic              accept_s;
  mem_port_t         gport_s;
  logic [XLEN-1:0]   g_addr_s;
  logic              g_we_s;
  write_width_t      g_wwidth_s;
  logic [XLEN-1:0]   g_wdata_s;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  mem_port_t         last_grant_q, last_grant_d;
  assign last_grant_s = last_grant_q;
`else
  assign last_grant_s = PORT_AUX;
`endif

  // Grants are suppressed during reset so no request is accepted then.
  assign idle_s = (state_q == IDLE) && !reset;

  mem_arb_grant u_grant (
    .valid_i      ({req1_valid, req0_valid}),
    .last_grant_i (last_grant_s),
    .idle_i       (idle_s),
    .grant_o      (grant_s)
  );

  // Ready handshake and selection of the granted requester's fields.
  always_comb begin
    req0_ready = grant_s[0];
    req1_ready = grant_s[1];
    accept_s   = |grant_s;
    gport_s    = onehot_to_port(grant_s);
    if (grant_s[1]) begin
      g_addr_s   = req1_addr;
      g_we_s     = req1_wenable;
      g_wwidth_s = req1_wwidth;
      g_wdata_s  = req1_wdata;
    end else begin
      g_addr_s   = req0_addr;
      g_we_s     = req0_wenable;
      g_wwidth_s = req0_wwidth;
      g_wdata_s  = req0_wdata;
    end
  end

  // Memory-side drive: pass-through in IDLE, latched address while reading.
  always_comb begin
    mem_addr    = {XLEN{1'b0}};
    mem_wwidth  = WIDTH_BYTE;
    mem_wenable = 1'b0;
    mem_wdata   = {XLEN{1'b0}};
    if (state_q == READ_WAIT) begin
      mem_addr = addr_q;
    end else if (accept_s) begin
      mem_addr    = g_addr_s;
      mem_wwidth  = g_wwidth_s;
      mem_wenable = g_we_s;
      mem_wdata   = g_wdata_s;
    end else begin
      mem_addr = {XLEN{1'b0}};
    end
  end

  // Next-state logic: accept requests, count read latency, capture data.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    port_d       = port_q;
    addr_d       = addr_q;
    resp_valid_d = 2'b00;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_s) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
          last_grant_d = gport_s;
`endif
          if (g_we_s) begin
            resp_valid_d = (gport_s == PORT_AUX) ? 2'b10 : 2'b01;
          end else begin
            state_d = READ_WAIT;
            cnt_d   = CNT_W'(READ_LATENCY);
            port_d  = gport_s;
            addr_d  = g_addr_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ_WAIT: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = IDLE;
          if (port_q == PORT_AUX) begin
            rdata1_d     = mem_rdata;
            resp_valid_d = 2'b10;
          end else begin
            rdata0_d     = mem_rdata;
            resp_valid_d = 2'b01;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      port_q       <= PORT_HART;
      addr_q       <= {XLEN{1'b0}};
      resp_valid_q <= 2'b00;
      rdata0_q     <= {XLEN{1'b0}};
      rdata1_q     <= {XLEN{1'b0}};
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_grant_q <= PORT_AUX;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      port_q       <= port_d;
      addr_q       <= addr_d;
      resp_valid_q <= resp_valid_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign resp0_valid = resp_valid_q[0];
  assign resp1_valid = resp_valid_q[1];
  assign resp0_rdata = rdata0_q;
  assign resp1_rdata = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (default READ_LATENCY = 2).
module tb_mem_arbiter;
  import isa_types::*;

  logic               clock;
  logic               reset;
  logic               req0_valid, req0_ready, req0_wenable;
  logic [31:0]        req0_addr, req0_wdata;
  write_width_t       req0_wwidth;
  logic               resp0_valid;
  logic [31:0]        resp0_rdata;
  logic               req1_valid, req1_ready, req1_wenable;
  logic [31:0]        req1_addr, req1_wdata;
  write_width_t       req1_wwidth;
  logic               resp1_valid;
  logic [31:0]        resp1_rdata;
  logic [31:0]        mem_addr, mem_wdata, mem_rdata;
  write_width_t       mem_wwidth;
  logic               mem_wenable;

  logic [31:0]        mem_s [0:255];
  logic               preload;
  int                 n_cmp;
  int                 n_err;
  int                 exp_port;

  mem_arbiter #(.READ_LATENCY(2)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_wenable(req0_wenable), .req0_wwidth(req0_wwidth), .req0_wdata(req0_wdata),
    .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_wenable(req1_wenable), .req1_wwidth(req1_wwidth), .req1_wdata(req1_wdata),
    .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata),
    .mem_addr(mem_addr), .mem_wwidth(mem_wwidth), .mem_wenable(mem_wenable),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Word-addressed memory model: combinational read, write on the clock edge.
  assign mem_rdata = mem_s[mem_addr[9:2]];
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem_s[i] <= 32'h0;
      mem_s[8'h40] <= 32'hDEADBEEF;
    end else if (mem_wenable) begin
      mem_s[mem_addr[9:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic set_req(input int p, input logic v, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
    if (p == 1) begin
      req1_valid = v; req1_wenable = we; req1_addr = a; req1_wdata = d; req1_wwidth = WIDTH_WORD;
    end else begin
      req0_valid = v; req0_wenable = we; req0_addr = a; req0_wdata = d; req0_wwidth = WIDTH_WORD;
    end
  endtask

  function automatic logic get_ready(input int p);
    return (p == 1) ? req1_ready : req0_ready;
  endfunction

  function automatic logic get_rvalid(input int p);
    return (p == 1) ? resp1_valid : resp0_valid;
  endfunction

  function automatic logic [31:0] get_rdata(input int p);
    return (p == 1) ? resp1_rdata : resp0_rdata;
  endfunction

  // Single read: accept in cycle 0, response exactly in cycle 4.
  task automatic do_read(input int p, input logic [31:0] a, input logic [31:0] exp, input string tag);
    tick(); set_req(p, 1'b1, 1'b0, a, 32'h0); #1;
    chk({tag, "_ready"}, 32'(get_ready(p)), 32'd1);
    chk({tag, "_addr"}, mem_addr, a);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) set_req(p, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      chk({tag, "_rvalid"}, 32'(get_rvalid(p)), (k == 4) ? 32'd1 : 32'd0);
    end
    chk({tag, "_rdata"}, get_rdata(p), exp);
    tick(); #1;
    chk({tag, "_rvalid_end"}, 32'(get_rvalid(p)), 32'd0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1; preload = 1'b1;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Write presented while reset is high must be suppressed.
    tick(); preload = 1'b0;
    set_req(0, 1'b1, 1'b1, 32'h0, 32'hBAD0BAD0); #1;
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_wenable", 32'(mem_wenable), 32'd0);
    tick(); set_req(0, 1'b0, 1'b0, 32'h0, 32'h0); #1;
    tick(); reset = 1'b0; #1;
    chk("rst_resp0_valid", 32'(resp0_valid), 32'd0);
    chk("rst_resp1_valid", 32'(resp1_valid), 32'd0);
    chk("rst_resp0_rdata", resp0_rdata, 32'h0);
    chk("rst_resp1_rdata", resp1_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    do_read(0, 32'h0, 32'h0, "rst_nowrite");

    // Single read of 0x100 on port 0.
    do_read(0, 32'h100, 32'hDEADBEEF, "rd0");

    // Single word write on port 1, then read it back.
    tick(); set_req(1, 1'b1, 1'b1, 32'h200, 32'h12345678); #1;
    chk("wr1_ready1", 32'(req1_ready), 32'd1);
    chk("wr1_ready0", 32'(req0_ready), 32'd0);
    chk("wr1_wenable", 32'(mem_wenable), 32'd1);
    chk("wr1_addr", mem_addr, 32'h200);
    chk("wr1_wdata", mem_wdata, 32'h12345678);
    chk("wr1_wwidth", 32'(mem_wwidth), 32'(WIDTH_WORD));
    tick(); set_req(1, 1'b0, 1'b0, 32'h0, 32'h0); #1;
    chk("wr1_wenable_c1", 32'(mem_wenable), 32'd0);
    chk("wr1_resp_c1", 32'(resp1_valid), 32'd1);
    chk("wr1_rdata_kept", resp1_rdata, 32'h0);
    tick(); #1;
    chk("wr1_resp_c2", 32'(resp1_valid), 32'd0);
    do_read(1, 32'h200, 32'h12345678, "rd1");

    // Contention: both ports request reads continuously.
    tick();
    set_req(0, 1'b1, 1'b0, 32'h100, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h200, 32'h0); #1;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      exp_port = i % 2;
`else
      exp_port = 0;
`endif
      chk("cont_ready0", 32'(req0_ready), (exp_port == 0) ? 32'd1 : 32'd0);
      chk("cont_ready1", 32'(req1_ready), (exp_port == 1) ? 32'd1 : 32'd0);
      for (int k = 1; k <= 3; k++) begin
        tick(); #1;
        chk("cont_busy_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      end
      tick(); #1;
      chk("cont_rvalid", 32'(get_rvalid(exp_port)), 32'd1);
      chk("cont_rdata", get_rdata(exp_port), (exp_port == 1) ? 32'h12345678 : 32'hDEADBEEF);
    end
    tick();
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (5) tick();

    // Busy: port 1 waits through port 0's read, accepted in the resp cycle.
    tick(); set_req(0, 1'b1, 1'b0, 32'h100, 32'h0); #1;
    chk("busy_ready0", 32'(req0_ready), 32'd1);
    tick(); set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h200, 32'h0); #1;
    chk("busy_ready1_c1", 32'(req1_ready), 32'd0);
    tick(); #1;
    chk("busy_ready1_c2", 32'(req1_ready), 32'd0);
    tick(); #1;
    chk("busy_ready1_c3", 32'(req1_ready), 32'd0);
    tick(); #1;
    chk("busy_resp0_c4", 32'(resp0_valid), 32'd1);
    chk("busy_ready1_c4", 32'(req1_ready), 32'd1);
    tick(); set_req(1, 1'b0, 1'b0, 32'h0, 32'h0); #1;
    chk("busy_resp1_c5", 32'(resp1_valid), 32'd0);
    tick(); tick(); tick(); #1;
    chk("busy_resp1_c8", 32'(resp1_valid), 32'd1);
    chk("busy_rdata1", resp1_rdata, 32'h12345678);

    // Reset in cycle 2 of a read aborts it.
    tick(); tick(); set_req(0, 1'b1, 1'b0, 32'h100, 32'h0); #1;
    chk("abort_ready0", 32'(req0_ready), 32'd1);
    tick(); set_req(0, 1'b0, 1'b0, 32'h0, 32'h0); #1;
    tick(); reset = 1'b1; #1;
    tick(); reset = 1'b0; #1;
    chk("abort_resp0_c3", 32'(resp0_valid), 32'd0);
    chk("abort_rdata0", resp0_rdata, 32'h0);
    chk("abort_idle_addr", mem_addr, 32'h0);
    tick(); #1;
    chk("abort_resp0_c4", 32'(resp0_valid), 32'd0);
    do_read(1, 32'h200, 32'h12345678, "abort_rd1");

    // Back-to-back writes from port 0.
    tick(); set_req(0, 1'b1, 1'b1, 32'h0, 32'hA5A5A5A5); #1;
    chk("b2b_ready_a", 32'(req0_ready), 32'd1);
    chk("b2b_wen_a", 32'(mem_wenable), 32'd1);
    chk("b2b_addr_a", mem_addr, 32'h0);
    tick(); set_req(0, 1'b1, 1'b1, 32'h4, 32'h5A5A5A5A); #1;
    chk("b2b_ready_b", 32'(req0_ready), 32'd1);
    chk("b2b_wen_b", 32'(mem_wenable), 32'd1);
    chk("b2b_addr_b", mem_addr, 32'h4);
    chk("b2b_resp_a", 32'(resp0_valid), 32'd1);
    tick(); set_req(0, 1'b0, 1'b0, 32'h0, 32'h0); #1;
    chk("b2b_resp_b", 32'(resp0_valid), 32'd1);
    chk("b2b_wen_off", 32'(mem_wenable), 32'd0);
    tick(); #1;
    chk("b2b_resp_end", 32'(resp0_valid), 32'd0);
    chk("b2b_rdata_kept", resp0_rdata, 32'h0);
    do_read(0, 32'h4, 32'h5A5A5A5A, "b2b_rd4");
    do_read(0, 32'h0, 32'hA5A5A5A5, "b2b_rd0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
